sfence_flush_sequencer: RTL
===========================

// Module: sfence_flush_sequencer
// PURPOSE
//  Sequences SFENCE.VMA execution between the execute stage's CSR port and the LSU/MMU.
//  Captures rs1/rs2 operands and the scoreboard trans_id, then waits for all pending stores
//  and the dcache write buffer to drain. Then drives a TLB flush for a fixed number of cycles
//  and reports completion on a single-cycle done strobe.
//  Owns the operand-hold registers, so the TLB sees stable operands for the whole flush window.
// PARAMETERS
//  VLEN          32   virtual address width (rs1 operand)
//  ASID_WIDTH    1    ASID width taken from rs2[ASID_WIDTH-1:0]
//  TRANS_ID_BITS 3    scoreboard transaction id width
//  FLUSH_CYCLES  1    cycles flush_tlb_o is held high (>=1)
//  MAX_WAIT      255  drain-wait watchdog limit in cycles (>=1); counter width $clog2(MAX_WAIT+1)
// PORTS
//  clk_i                  in   1              clock
//  rst_ni                 in   1              synchronous reset, active low
//  flush_i                in   1              pipeline flush
//  sfence_valid_i         in   1              SFENCE.VMA issued this cycle
//  sfence_ready_o         out  1              sequencer idle, can accept
//  rs1_i                  in   VLEN           forwarded rs1 (vaddr)
//  rs2_i                  in   VLEN           forwarded rs2 (asid in low bits)
//  rs1_zero_i             in   1              rs1 index is x0 -> all addresses
//  rs2_zero_i             in   1              rs2 index is x0 -> all ASIDs
//  trans_id_i             in   TRANS_ID_BITS  scoreboard id of the sfence
//  no_st_pending_i        in   1              LSU store buffer empty
//  dcache_wbuffer_empty_i in   1              dcache write buffer empty
//  flush_tlb_o            out  1              TLB flush request
//  vaddr_o                out  VLEN           held vaddr to flush
//  asid_o                 out  ASID_WIDTH     held ASID to flush
//  flush_all_vaddr_o      out  1              ignore vaddr_o
//  flush_all_asid_o       out  1              ignore asid_o
//  done_o                 out  1              1-cycle completion strobe
//  done_trans_id_o        out  TRANS_ID_BITS  id accompanying done_o
//  timeout_o              out  1              1-cycle strobe: watchdog expired during drain
// BEHAVIOUR
//  - Every state and output register resets to 0 on the clock edge with rst_ni=0; state=IDLE.
//  - All outputs are registered, except sfence_ready_o = (state==IDLE).
//  - IDLE: accept when sfence_valid_i & ~flush_i.
//    - On accept, latch rs1_i -> vaddr_o, rs2_i[ASID_WIDTH-1:0] -> asid_o,
//      rs1_zero_i/rs2_zero_i -> flush_all_*_o, trans_id_i -> done_trans_id_o.
//    - Clear wait_cnt and go to DRAIN.
//  - DRAIN: each cycle evaluate no_st_pending_i & dcache_wbuffer_empty_i.
//    - If true, go to FLUSH.
//    - Else wait_cnt++; when wait_cnt==MAX_WAIT-1, pulse timeout_o next cycle and go to FLUSH.
//  - DRAIN + flush_i: abort to IDLE. No flush_tlb_o, no done_o; held operands cleared.
//  - FLUSH: flush_tlb_o=1 for exactly FLUSH_CYCLES cycles (flush_cnt), then DONE.
//    - flush_i is ignored here; a started TLB flush always completes.
//  - DONE: done_o=1 for one cycle, then IDLE.
//    - vaddr_o/asid_o/flush_all_* stay stable from accept through the DONE cycle.
//  - sfence_valid_i while not IDLE is not accepted; the issuer holds or re-issues.
//  - Latency with a drained LSU at accept (cycle 0):
//    - DRAIN in cycle 1; flush_tlb_o high cycles 2..1+FLUSH_CYCLES;
//      done_o in cycle 2+FLUSH_CYCLES; sfence_ready_o high again at 3+FLUSH_CYCLES.
//  - wait_cnt saturates and never wraps.
//  - Reset mid-operation returns to IDLE with flush_tlb_o=0 the next cycle.
// TESTING
//  - Drained: FLUSH_CYCLES=1; valid, rs1=0x8000_1000, rs2=0x1, id=5, drains high
//    -> flush_tlb_o cycle 2, vaddr_o=0x8000_1000, asid_o=1; done_o cycle 3, id=5.
//  - Store pending: no_st_pending_i low for 10 cycles after accept
//    -> flush_tlb_o rises 1 cycle after it goes high; timeout_o stays 0.
//  - Watchdog: MAX_WAIT=8, drains stuck low -> timeout_o pulse, flush_tlb_o asserted,
//    done_o follows; total 8+FLUSH_CYCLES+2 cycles from accept.
//  - Abort: flush_i in DRAIN -> IDLE next cycle; flush_tlb_o and done_o never assert.
//    Second case: flush_i during FLUSH -> flush completes and done_o fires.
//  - Back-to-back: second valid while busy -> ignored (ready=0);
//    re-issue after done -> second flush uses the new operands; x0 flags propagate to flush_all_*.
//  - Reset: rst_ni low during FLUSH -> next cycle all outputs 0, sfence_ready_o=1.

Source files
------------

// File: rtl/sfence_flush_sequencer_if.sv
// Bus between the execute stage / LSU side and the SFENCE.VMA sequencer.
// The master is the execute stage + LSU; the slave is the sequencer.
interface sfence_flush_sequencer_if #(
   parameter int unsigned VLEN          = 32,
   parameter int unsigned ASID_WIDTH    = 1,
   parameter int unsigned TRANS_ID_BITS = 3
);
   // issue side
   logic                     flush_i;
   logic                     sfence_valid_i;
   logic                     sfence_ready_o;
   logic [VLEN-1:0]          rs1_i;
   logic [VLEN-1:0]          rs2_i;
   logic                     rs1_zero_i;
   logic                     rs2_zero_i;
   logic [TRANS_ID_BITS-1:0] trans_id_i;
   // drain status from the LSU / dcache
   logic                     no_st_pending_i;
   logic                     dcache_wbuffer_empty_i;
   // TLB flush request and completion
   logic                     flush_tlb_o;
   logic [VLEN-1:0]          vaddr_o;
   logic [ASID_WIDTH-1:0]    asid_o;
   logic                     flush_all_vaddr_o;
   logic                     flush_all_asid_o;
   logic                     done_o;
   logic [TRANS_ID_BITS-1:0] done_trans_id_o;
   logic                     timeout_o;

   modport master (
      output flush_i, sfence_valid_i, rs1_i, rs2_i, rs1_zero_i, rs2_zero_i, trans_id_i,
             no_st_pending_i, dcache_wbuffer_empty_i,
      input  sfence_ready_o, flush_tlb_o, vaddr_o, asid_o, flush_all_vaddr_o,
             flush_all_asid_o, done_o, done_trans_id_o, timeout_o
   );

   modport slave (
      input  flush_i, sfence_valid_i, rs1_i, rs2_i, rs1_zero_i, rs2_zero_i, trans_id_i,
             no_st_pending_i, dcache_wbuffer_empty_i,
      output sfence_ready_o, flush_tlb_o, vaddr_o, asid_o, flush_all_vaddr_o,
             flush_all_asid_o, done_o, done_trans_id_o, timeout_o
   );
endinterface

// File: rtl/sfence_flush_sequencer.sv
// SFENCE.VMA sequencer: captures the operands, waits for the store path to drain
// (with a watchdog), holds the TLB flush for a fixed window and strobes completion.
// The operand-hold registers keep the TLB inputs stable from accept through DONE.
module sfence_flush_sequencer #(
   parameter int unsigned VLEN          = 32,
   parameter int unsigned ASID_WIDTH    = 1,
   parameter int unsigned TRANS_ID_BITS = 3,
   parameter int unsigned FLUSH_CYCLES  = 1,
   parameter int unsigned MAX_WAIT      = 255
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   sfence_flush_sequencer_if.slave bus
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
   localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_FLUSH,
      S_DONE
   } state_e;

   state_e                   state_q, state_d;
   logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
   logic [FCNT_W-1:0]        flush_cnt_q, flush_cnt_d;
   logic [VLEN-1:0]          vaddr_q, vaddr_d;
   logic [ASID_WIDTH-1:0]    asid_q, asid_d;
   logic                     flush_all_vaddr_q, flush_all_vaddr_d;
   logic                     flush_all_asid_q, flush_all_asid_d;
   logic [TRANS_ID_BITS-1:0] trans_id_q, trans_id_d;
   logic                     flush_tlb_q, flush_tlb_d;
   logic                     done_q, done_d;
   logic                     timeout_q, timeout_d;

   logic drained;
   assign drained = bus.no_st_pending_i & bus.dcache_wbuffer_empty_i;

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d           = state_q;
      wait_cnt_d        = wait_cnt_q;
      flush_cnt_d       = flush_cnt_q;
      vaddr_d           = vaddr_q;
      asid_d            = asid_q;
      flush_all_vaddr_d = flush_all_vaddr_q;
      flush_all_asid_d  = flush_all_asid_q;
      trans_id_d        = trans_id_q;
      flush_tlb_d       = 1'b0;
      done_d            = 1'b0;
      timeout_d         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.sfence_valid_i && !bus.flush_i) begin
               vaddr_d           = bus.rs1_i;
               asid_d            = bus.rs2_i[ASID_WIDTH-1:0];
               flush_all_vaddr_d = bus.rs1_zero_i;
               flush_all_asid_d  = bus.rs2_zero_i;
               trans_id_d        = bus.trans_id_i;
               wait_cnt_d        = '0;
               state_d           = S_DRAIN;
            end
         end

         S_DRAIN: begin
            if (bus.flush_i) begin
               // Squashed before the TLB was touched: drop the held operands.
               vaddr_d           = '0;
               asid_d            = '0;
               flush_all_vaddr_d = 1'b0;
               flush_all_asid_d  = 1'b0;
               trans_id_d        = '0;
               wait_cnt_d        = '0;
               state_d           = S_IDLE;
            end else if (drained) begin
               flush_tlb_d = 1'b1;
               flush_cnt_d = '0;
               state_d     = S_FLUSH;
            end else if (wait_cnt_q == WAIT_LAST) begin
               // Watchdog: stop waiting and flush anyway, flagging the timeout.
               timeout_d   = 1'b1;
               flush_tlb_d = 1'b1;
               flush_cnt_d = '0;
               state_d     = S_FLUSH;
            end else begin
               // Always below WAIT_LAST here, so the counter cannot wrap.
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end

         S_FLUSH: begin
            // flush_i is deliberately ignored: a started TLB flush always completes.
            if (flush_cnt_q == FLUSH_LAST) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               flush_tlb_d = 1'b1;
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
      if (!rst_ni) begin
         state_q           <= S_IDLE;
         wait_cnt_q        <= '0;
         flush_cnt_q       <= '0;
         vaddr_q           <= '0;
         asid_q            <= '0;
         flush_all_vaddr_q <= 1'b0;
         flush_all_asid_q  <= 1'b0;
         trans_id_q        <= '0;
         flush_tlb_q       <= 1'b0;
         done_q            <= 1'b0;
         timeout_q         <= 1'b0;
      end else begin
         state_q           <= state_d;
         wait_cnt_q        <= wait_cnt_d;
         flush_cnt_q       <= flush_cnt_d;
         vaddr_q           <= vaddr_d;
         asid_q            <= asid_d;
         flush_all_vaddr_q <= flush_all_vaddr_d;
         flush_all_asid_q  <= flush_all_asid_d;
         trans_id_q        <= trans_id_d;
         flush_tlb_q       <= flush_tlb_d;
         done_q            <= done_d;
         timeout_q         <= timeout_d;
      end
   end

   assign bus.sfence_ready_o    = (state_q == S_IDLE);
   assign bus.flush_tlb_o       = flush_tlb_q;
   assign bus.vaddr_o           = vaddr_q;
   assign bus.asid_o            = asid_q;
   assign bus.flush_all_vaddr_o = flush_all_vaddr_q;
   assign bus.flush_all_asid_o  = flush_all_asid_q;
   assign bus.done_o            = done_q;
   assign bus.done_trans_id_o   = trans_id_q;
   assign bus.timeout_o         = timeout_q;

endmodule
